// File: rtl/sample_frame_distributor_pkg.sv
// Shared definitions for the sample frame distributor: default sizing,
// the controller state encoding and a small period legality helper.
package sample_frame_distributor_pkg;

  localparam int NUM_CHANNELS_DEFAULT = 8;
  localparam int WORD_WIDTH_DEFAULT   = 16;
  localparam int MIN_PERIOD_DEFAULT   = 16;
  localparam int PERIOD_WIDTH         = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIME   = 2'd1,
    RUNNING = 2'd2,
    ERROR   = 2'd3
  } sfd_state_e;

  // A period shorter than the minimum cannot be serviced by a streaming source.
  function automatic logic period_too_short(input logic [PERIOD_WIDTH-1:0] p,
                                            input int min_p);
    return (p < PERIOD_WIDTH'(min_p));
  endfunction

endpackage

// File: rtl/sample_frame_distributor.sv
// Collects one frame of per-channel samples from a ready/valid stream into a
// staging bank, then publishes the whole frame to the channel outputs on a
// fixed cadence of 'period' clocks. A missing frame at publish time is a
// sticky underflow error; the block then freezes until reset.
module sample_frame_distributor
  import sample_frame_distributor_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEFAULT,
  parameter int WORD_WIDTH   = WORD_WIDTH_DEFAULT,
  parameter int MIN_PERIOD   = MIN_PERIOD_DEFAULT
) (
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic                               enable,
  input  logic [PERIOD_WIDTH-1:0]            period,
  input  logic [WORD_WIDTH-1:0]              s_tdata,
  input  logic                               s_tvalid,
  output logic                               s_tready,
  output logic [NUM_CHANNELS*WORD_WIDTH-1:0] value_out_concat,
  output logic [NUM_CHANNELS-1:0]            value_ready_concat,
  output logic                               setup_done,
  output logic                               err_underflow,
  output logic                               err_period
);

  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  sfd_state_e                state_q, state_d;
  logic [PERIOD_WIDTH-1:0]   period_q, period_d;
  logic [PERIOD_WIDTH-1:0]   update_timer_q, update_timer_d;
  logic [IDX_W-1:0]          word_idx_q, word_idx_d;
  logic                      frame_pending_q, frame_pending_d;
  logic                      setup_done_q, setup_done_d;
  logic                      err_underflow_q, err_underflow_d;
  logic                      err_period_q, err_period_d;
  logic [NUM_CHANNELS-1:0]   value_ready_q, value_ready_d;

  logic accept;
  logic load_outputs;

  // The stream is only drained while priming or running and while the staging
  // bank is free; a complete frame blocks intake until it has been published.
  assign s_tready = ((state_q == PRIME) || (state_q == RUNNING)) && !frame_pending_q;
  assign accept   = s_tvalid && s_tready;

  assign value_ready_concat = value_ready_q;
  assign setup_done         = setup_done_q;
  assign err_underflow      = err_underflow_q;
  assign err_period         = err_period_q;

  // Controller next-state: period latch, word indexing, frame hand-off and cadence timer.
  always_comb begin
    state_d         = state_q;
    period_d        = period_q;
    update_timer_d  = update_timer_q;
    word_idx_d      = word_idx_q;
    frame_pending_d = frame_pending_q;
    setup_done_d    = setup_done_q;
    err_underflow_d = err_underflow_q;
    err_period_d    = err_period_q;
    value_ready_d   = '0;
    load_outputs    = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          period_d        = period;
          word_idx_d      = '0;
          frame_pending_d = 1'b0;
          if (period_too_short(period, MIN_PERIOD)) begin
            err_period_d = 1'b1;
            state_d      = ERROR;
          end else begin
            state_d = PRIME;
          end
        end
      end

      PRIME, RUNNING: begin
        if (!enable) begin
          // Dropping enable abandons any partial or pending frame but keeps
          // the last published values on the outputs.
          state_d         = IDLE;
          setup_done_d    = 1'b0;
          frame_pending_d = 1'b0;
          word_idx_d      = '0;
        end else begin
          if (state_q == PRIME) begin
            if (frame_pending_q) begin
              load_outputs    = 1'b1;
              frame_pending_d = 1'b0;
              setup_done_d    = 1'b1;
              update_timer_d  = period_q - PERIOD_WIDTH'(1);
              state_d         = RUNNING;
            end
          end else begin
            if (update_timer_q == '0) begin
              update_timer_d = period_q - PERIOD_WIDTH'(1);
              if (frame_pending_q) begin
                load_outputs    = 1'b1;
                frame_pending_d = 1'b0;
              end else begin
                // A frame finishing on this very edge is still too late.
                err_underflow_d = 1'b1;
                state_d         = ERROR;
              end
            end else begin
              update_timer_d = update_timer_q - PERIOD_WIDTH'(1);
            end
          end

          // Accept can only happen while no frame is pending, so it never
          // collides with the publish path clearing frame_pending.
          if (accept) begin
            if (word_idx_q == LAST_IDX) begin
              word_idx_d      = '0;
              frame_pending_d = 1'b1;
            end else begin
              word_idx_d = word_idx_q + IDX_W'(1);
            end
          end
        end
      end

      ERROR: begin
        state_d = ERROR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_outputs) begin
      value_ready_d = '1;
    end
  end

  // Controller registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q         <= IDLE;
      period_q        <= '0;
      update_timer_q  <= '0;
      word_idx_q      <= '0;
      frame_pending_q <= 1'b0;
      setup_done_q    <= 1'b0;
      err_underflow_q <= 1'b0;
      err_period_q    <= 1'b0;
      value_ready_q   <= '0;
    end else begin
      state_q         <= state_d;
      period_q        <= period_d;
      update_timer_q  <= update_timer_d;
      word_idx_q      <= word_idx_d;
      frame_pending_q <= frame_pending_d;
      setup_done_q    <= setup_done_d;
      err_underflow_q <= err_underflow_d;
      err_period_q    <= err_period_d;
      value_ready_q   <= value_ready_d;
    end
  end

  // One staging slot and one published output register per channel.
  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
    logic [WORD_WIDTH-1:0] staging_q, staging_d;
    logic [WORD_WIDTH-1:0] value_q, value_d;

    // Capture the stream word addressed to this channel and publish staging on an update edge.
    always_comb begin
      staging_d = staging_q;
      value_d   = value_q;
      if (accept && (word_idx_q == IDX_W'(ch))) begin
        staging_d = s_tdata;
      end
      if (load_outputs) begin
        value_d = staging_q;
      end
    end

    // Per-channel registers; reset discards any partially staged frame.
    always_ff @(posedge clk) begin
      if (!aresetn) begin
        staging_q <= '0;
        value_q   <= '0;
      end else begin
        staging_q <= staging_d;
        value_q   <= value_d;
      end
    end

    assign value_out_concat[ch*WORD_WIDTH +: WORD_WIDTH] = value_q;
  end

endmodule

// File: tb/tb_sample_frame_distributor.sv
// Self-checking bench for sample_frame_distributor. A frame-level reference
// model (word queue, publish deadlines as absolute edge numbers) predicts
// every output each cycle; directed scenarios cover priming, cadence,
// underflow, illegal periods, disable and mid-frame reset.
module tb_sample_frame_distributor;

  localparam int NCH  = 8;
  localparam int WW   = 16;
  localparam int MINP = 16;

  logic             clk = 1'b0;
  logic             aresetn;
  logic             enable;
  logic [31:0]      period;
  logic [WW-1:0]    s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic [NCH*WW-1:0] value_out_concat;
  logic [NCH-1:0]   value_ready_concat;
  logic             setup_done;
  logic             err_underflow;
  logic             err_period;

  int tests_run    = 0;
  int tests_failed = 0;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  sample_frame_distributor #(
    .NUM_CHANNELS(NCH),
    .WORD_WIDTH  (WW),
    .MIN_PERIOD  (MINP)
  ) dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .enable            (enable),
    .period            (period),
    .s_tdata           (s_tdata),
    .s_tvalid          (s_tvalid),
    .s_tready          (s_tready),
    .value_out_concat  (value_out_concat),
    .value_ready_concat(value_ready_concat),
    .setup_done        (setup_done),
    .err_underflow     (err_underflow),
    .err_period        (err_period)
  );

  typedef enum int {M_IDLE, M_PRIME, M_RUN, M_ERR} mode_e;

  mode_e       m_mode;
  logic [15:0] m_stage[$];
  logic [15:0] m_pend[NCH];
  bit          m_pend_v;
  logic [15:0] m_out[NCH];
  bit          m_setup, m_eu, m_ep, m_pulse;
  int unsigned m_per;
  longint      m_edge;
  longint      m_next_due;

  bit          last_accept;
  logic [31:0] cur_period;
  bit          spacing_check;
  longint      prev_pulse_edge;

  // Watchdog so the bench can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit modelReady();
    return ((m_mode == M_PRIME) || (m_mode == M_RUN)) && !m_pend_v;
  endfunction

  function automatic logic [127:0] modelOutConcat();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[i*16 +: 16] = m_out[i];
    return r;
  endfunction

  function automatic logic [127:0] frameConcat(input logic [15:0] w[NCH]);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[i*16 +: 16] = w[i];
    return r;
  endfunction

  task automatic modelReset();
    m_mode     = M_IDLE;
    m_stage.delete();
    m_pend_v   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_out[i]  = '0;
      m_pend[i] = '0;
    end
    m_setup    = 1'b0;
    m_eu       = 1'b0;
    m_ep       = 1'b0;
    m_pulse    = 1'b0;
    m_per      = 0;
    m_next_due = 0;
  endtask

  task automatic modelDeliver();
    for (int i = 0; i < NCH; i++) m_out[i] = m_pend[i];
    m_pend_v = 1'b0;
    m_pulse  = 1'b1;
  endtask

  // Advance the reference model across one rising edge.
  task automatic modelEdge(input logic rstn, input logic en, input logic valid,
                           input logic [15:0] data, input logic [31:0] per);
    bit acc;
    acc = valid && modelReady();
    m_edge++;
    m_pulse = 1'b0;
    if (!rstn) begin
      modelReset();
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (en) begin
          m_per = per;
          m_stage.delete();
          if (per < MINP) begin
            m_ep   = 1'b1;
            m_mode = M_ERR;
          end else begin
            m_mode = M_PRIME;
          end
        end
      end
      M_PRIME, M_RUN: begin
        if (!en) begin
          m_mode   = M_IDLE;
          m_setup  = 1'b0;
          m_pend_v = 1'b0;
          m_stage.delete();
        end else begin
          if (m_mode == M_PRIME && m_pend_v) begin
            modelDeliver();
            m_setup    = 1'b1;
            m_next_due = m_edge + m_per;
            m_mode     = M_RUN;
          end else if (m_mode == M_RUN && m_edge == m_next_due) begin
            if (m_pend_v) begin
              modelDeliver();
              m_next_due = m_next_due + m_per;
            end else begin
              m_eu   = 1'b1;
              m_mode = M_ERR;
            end
          end
          if (acc) begin
            m_stage.push_back(data);
            if (m_stage.size() == NCH) begin
              for (int i = 0; i < NCH; i++) m_pend[i] = m_stage[i];
              m_pend_v = 1'b1;
              m_stage.delete();
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("value_out", value_out_concat, modelOutConcat());
    checkVal("value_ready", 128'(value_ready_concat), m_pulse ? 128'hFF : 128'h0);
    checkVal("setup_done", 128'(setup_done), 128'(m_setup));
    checkVal("err_underflow", 128'(err_underflow), 128'(m_eu));
    checkVal("err_period", 128'(err_period), 128'(m_ep));
  endtask

  // Drive one cycle of inputs, check combinational ready, then check registered outputs after the edge.
  task automatic applyStimulus(input logic rstn, input logic en, input logic valid,
                               input logic [15:0] data, input logic [31:0] per);
    @(negedge clk);
    aresetn  = rstn;
    enable   = en;
    s_tvalid = valid;
    s_tdata  = data;
    period   = per;
    #1;
    checkVal("s_tready", 128'(s_tready), 128'(modelReady()));
    last_accept = valid && modelReady();
    @(posedge clk);
    modelEdge(rstn, en, valid, data, per);
    #1;
    checkOutput();
    if (value_ready_concat !== '0) begin
      if (spacing_check && prev_pulse_edge >= 0)
        checkVal("update_spacing", 128'(m_edge - prev_pulse_edge), 128'(cur_period));
      prev_pulse_edge = m_edge;
    end
  endtask

  task automatic feedWords(input logic [15:0] w[NCH], input int n, input int gap_pct,
                           input int max_cycles);
    int k;
    int c;
    bit v;
    k = 0;
    c = 0;
    while (k < n && c < max_cycles && m_mode != M_ERR) begin
      v = ($urandom_range(99) >= gap_pct);
      applyStimulus(1'b1, 1'b1, v, w[k], cur_period);
      if (last_accept) k++;
      c++;
    end
    checkVal("feed_progress", 128'(k == n || m_mode == M_ERR), 128'(1));
  endtask

  task automatic randFrame(output logic [15:0] w[NCH]);
    for (int i = 0; i < NCH; i++) w[i] = 16'($urandom);
  endtask

  task automatic idleCycles(input logic en, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, en, 1'b0, 16'h0, cur_period);
  endtask

  task automatic resetCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, cur_period);
  endtask

  // Directed scenarios in sequence, each finishing with the DUT back in reset.
  initial begin
    logic [15:0] w[NCH];
    logic [15:0] f1[NCH];

    aresetn  = 1'b0;
    enable   = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    period   = '0;
    cur_period      = 32'd0;
    spacing_check   = 1'b0;
    prev_pulse_edge = -1;
    last_accept     = 1'b0;
    m_edge          = 0;
    modelReset();
    repeat (2) @(posedge clk);

    resetCycle();
    resetCycle();

    // Ordered words 0x8000.. at period 100, then disable while running.
    cur_period = 32'd100;
    for (int i = 0; i < NCH; i++) w[i] = 16'h8000 + 16'(i);
    feedWords(w, NCH, 0, 40);
    idleCycles(1'b1, 1);
    checkVal("prime_setup_rise", 128'(setup_done), 128'(1));
    checkVal("prime_ch3", 128'(value_out_concat[63:48]), 128'h8003);
    checkVal("prime_pulse", 128'(value_ready_concat), 128'hFF);
    idleCycles(1'b1, 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, cur_period);
    checkVal("disable_setup_low", 128'(setup_done), 128'(0));
    checkVal("disable_hold_values", value_out_concat, frameConcat(w));
    idleCycles(1'b0, 3);

    // Continuous frames at period 20 with cadence measurement, ending in underflow.
    cur_period      = 32'd20;
    spacing_check   = 1'b1;
    prev_pulse_edge = -1;
    for (int f = 0; f < 5; f++) begin
      randFrame(w);
      feedWords(w, NCH, 0, 60);
    end
    for (int c = 0; c < 80 && m_mode != M_ERR; c++) idleCycles(1'b1, 1);
    checkVal("stream_end_underflow", 128'(err_underflow), 128'(1));
    spacing_check = 1'b0;
    resetCycle();

    // Frame 2 stalls after five words: underflow on the next deadline, outputs frozen.
    cur_period = 32'd20;
    randFrame(f1);
    feedWords(f1, NCH, 0, 40);
    idleCycles(1'b1, 1);
    randFrame(w);
    feedWords(w, 5, 0, 20);
    for (int c = 0; c < 40 && m_mode != M_ERR; c++) idleCycles(1'b1, 1);
    checkVal("stall_underflow", 128'(err_underflow), 128'(1));
    checkVal("stall_tready", 128'(s_tready), 128'(0));
    checkVal("stall_hold_frame1", value_out_concat, frameConcat(f1));
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 16'($urandom), cur_period);
    resetCycle();

    // Illegal and boundary periods.
    cur_period = 32'd10;
    idleCycles(1'b1, 3);
    checkVal("period10_err", 128'(err_period), 128'(1));
    checkVal("period10_setup", 128'(setup_done), 128'(0));
    resetCycle();
    cur_period = 32'd15;
    idleCycles(1'b1, 2);
    checkVal("period15_err", 128'(err_period), 128'(1));
    resetCycle();
    cur_period = 32'd16;
    for (int f = 0; f < 3; f++) begin
      randFrame(w);
      feedWords(w, NCH, 0, 60);
    end
    idleCycles(1'b1, 4);
    checkVal("period16_no_err", 128'(err_period), 128'(0));
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, cur_period);
    resetCycle();

    // Reset in the middle of frame 2, then a clean restart with fresh data.
    cur_period = 32'd20;
    randFrame(f1);
    feedWords(f1, NCH, 0, 40);
    idleCycles(1'b1, 1);
    randFrame(w);
    feedWords(w, 4, 0, 20);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hDEAD, cur_period);
    checkVal("midreset_outputs", value_out_concat, 128'h0);
    randFrame(w);
    feedWords(w, NCH, 0, 40);
    idleCycles(1'b1, 1);
    checkVal("restart_values", value_out_concat, frameConcat(w));
    idleCycles(1'b1, 3);
    resetCycle();

    // Randomized runs: random period, gappy stream, random termination.
    for (int run = 0; run < 4; run++) begin
      cur_period = 32'($urandom_range(40, MINP));
      for (int f = 0; f < 6; f++) begin
        randFrame(w);
        feedWords(w, NCH, 30, 120);
      end
      idleCycles(1'b1, int'($urandom_range(30, 1)));
      if ($urandom_range(1) == 1) idleCycles(1'b0, 3);
      resetCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
